// File: rtl/uart_tx_framer_if.sv
// rtl/uart_tx_framer_if.sv - word input handshake for the UART transmit framer
interface uart_tx_framer_if #(
  parameter int DATA_BITS = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - FIFO-buffered UART transmitter, tick-paced framing
module uart_tx_framer #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  uart_tx_framer_if.slave               in_if,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 two_stop_q, two_stop_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 tx_q, tx_d;
  logic                 in_ready;
  logic                 push;
  logic                 pop;
  logic                 fifo_nonempty;

  assign in_ready       = (count_q != CW'(FIFO_DEPTH));
  assign in_if.in_ready = in_ready;
  assign push           = in_if.in_valid && in_ready;
  assign fifo_nonempty  = (count_q != '0);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    state_d    = state_q;
    data_d     = data_q;
    bit_idx_d  = bit_idx_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    pop        = 1'b0;

    if (push) begin
      mem_d[wr_ptr_q] = in_if.in_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    // tx_d always reflects the bit of the state being entered, so tx is a plain flop
    if (tick) begin
      case (state_q)
        IDLE: pop = fifo_nonempty;
        START: begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = data_q[0];
        end
        DATA: begin
          if (bit_idx_q == BW'(DATA_BITS - 1)) begin
            stop_idx_d = 1'b0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = (^data_q) ^ par_odd_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
            tx_d      = data_q[bit_idx_d];
          end
        end
        PARITY: begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
          tx_d       = 1'b1;
        end
        STOP: begin
          if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else if (fifo_nonempty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Frame launch: configuration is sampled here and held for the whole frame
    if (pop) begin
      state_d    = START;
      tx_d       = 1'b0;
      data_d     = mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PW'(1);
      par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_odd_d  = (parity_mode == 2'b10);
      two_stop_d = two_stop;
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      data_q     <= '0;
      bit_idx_q  <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      data_q     <= data_d;
      bit_idx_q  <= bit_idx_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - self-checking bench for uart_tx_framer
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick;
  logic       tick_en = 1'b0;
  int         div;
  logic [1:0] parity_mode = 2'b00;
  logic       two_stop = 1'b0;
  logic       tx;
  logic       tx_busy;
  logic [2:0] fifo_count;

  int tests = 0;
  int fails = 0;

  bit exp_tx[$];
  bit exp_busy[$];

  uart_tx_framer_if #(.DATA_BITS(8)) bus ();

  uart_tx_framer #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .in_if       (bus),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // One tick every fourth clock while enabled
  initial begin
    tick = 1'b0;
    div  = 0;
    forever begin
      @(negedge clk);
      div  = (div + 1) % 4;
      tick = tick_en && (div == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference frame: start, LSB-first data, optional parity, 1 or 2 stops; 4 clk per bit
  task automatic add_frame(input logic [7:0] w, input logic [1:0] pm, input bit two);
    bit bits[$];
    int ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(w[i]);
      ones += w[i];
    end
    if (pm == 2'b01) bits.push_back(bit'(ones % 2));
    if (pm == 2'b10) bits.push_back(bit'(1 - ones % 2));
    bits.push_back(1'b1);
    if (two) bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int r = 0; r < 4; r++) begin
        exp_tx.push_back(bits[k]);
        exp_busy.push_back(1'b1);
      end
    end
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endtask

  task automatic push_word(input string tag, input logic [7:0] w, input logic exp_rdy);
    chk({tag, "_in_ready"}, bus.in_ready, exp_rdy);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Compare tx/tx_busy per clock against the expected stream from the first low cycle
  task automatic run_frames(input string tag, input int chg_idx);
    int waited = 0;
    while (tx !== 1'b0 && waited < 400) begin
      step();
      waited++;
    end
    chk({tag, "_start_seen"}, 32'(waited < 400), 32'd1);
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (i == chg_idx) two_stop = 1'b0;
      chk($sformatf("%s_tx[%0d]", tag, i), tx, exp_tx[i]);
      chk($sformatf("%s_busy[%0d]", tag, i), tx_busy, exp_busy[i]);
      step();
    end
    exp_tx.delete();
    exp_busy.delete();
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] wq[$];
    int         n, bad, waited;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) step();
    chk("rst_tx", tx, 1'b1);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_ready", bus.in_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    reset = 1'b0;
    step();
    chk("post_rst_tx", tx, 1'b1);

    // 0x55, no parity, one stop
    tick_en = 1'b1;
    push_word("p55", 8'h55, 1'b1);
    add_frame(8'h55, 2'b00, 1'b0);
    add_idle(8);
    run_frames("f55", -1);

    parity_mode = 2'b01;
    push_word("p03e", 8'h03, 1'b1);
    add_frame(8'h03, 2'b01, 1'b0);
    add_idle(8);
    run_frames("f03_even", -1);

    parity_mode = 2'b10;
    push_word("p03o", 8'h03, 1'b1);
    add_frame(8'h03, 2'b10, 1'b0);
    add_idle(8);
    run_frames("f03_odd", -1);

    // two_stop dropped mid-frame must not shorten the stop period
    parity_mode = 2'b00;
    two_stop    = 1'b1;
    push_word("pff", 8'hFF, 1'b1);
    add_frame(8'hFF, 2'b00, 1'b1);
    add_idle(8);
    run_frames("fff_2stop", 20);

    // FIFO fill with ticks held off
    tick_en = 1'b0;
    step();
    for (int i = 0; i < 4; i++) push_word("fill", 8'hA1 + 8'(i), 1'b1);
    chk("full_ready", bus.in_ready, 1'b0);
    chk("full_count", fifo_count, 3'd4);
    push_word("fill5", 8'hA5, 1'b0);
    chk("full_count_after5", fifo_count, 3'd4);
    for (int i = 0; i < 4; i++) add_frame(8'hA1 + 8'(i), 2'b00, 1'b0);
    add_idle(8);
    tick_en = 1'b1;
    run_frames("fifo_b2b", -1);

    // Simultaneous push and launch with two queued
    tick_en = 1'b0;
    step();
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back(8'($urandom));
    push_word("sim1", wq[0], 1'b1);
    push_word("sim2", wq[1], 1'b1);
    chk("sim_count_pre", fifo_count, 3'd2);
    tick_en = 1'b1;
    waited = 0;
    while (tick !== 1'b1 && waited < 16) begin
      step();
      waited++;
    end
    chk("sim_tick_seen", 32'(waited < 16), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = wq[2];
    step();
    bus.in_valid = 1'b0;
    chk("sim_count_post", fifo_count, 3'd2);
    foreach (wq[i]) add_frame(wq[i], 2'b00, 1'b0);
    add_idle(8);
    run_frames("sim_order", -1);

    // Randomized bursts, configuration held per burst
    for (int b = 0; b < 6; b++) begin
      parity_mode = 2'($urandom_range(0, 3));
      two_stop    = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        w = 8'($urandom);
        push_word("rnd_push", w, 1'b1);
        add_frame(w, parity_mode, two_stop);
      end
      add_idle(8);
      run_frames($sformatf("rnd%0d", b), -1);
    end

    // Reset during data bit 3 with two words still queued
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    for (int i = 0; i < 3; i++) push_word("rst_push", 8'($urandom), 1'b1);
    waited = 0;
    while (tx !== 1'b0 && waited < 400) begin
      step();
      waited++;
    end
    chk("rst_frame_start", 32'(waited < 400), 32'd1);
    chk("rst_queued", fifo_count, 3'd2);
    repeat (17) step();
    reset = 1'b1;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_count", fifo_count, 3'd0);
    chk("midrst_ready", bus.in_ready, 1'b1);
    chk("midrst_busy", tx_busy, 1'b0);
    step();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("after_rst_quiet", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, data word width, legal 5..9.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, transmit FIFO entries, power of two, legal 2..16.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port tick  in  1  single-cycle bit-period strobe, one per bit time.
REQ-006 SHALL have port in_valid  in  1  word present on in_data.
REQ-007 SHALL have port in_ready  out  1  FIFO can accept a word.
REQ-008 SHALL have port in_data  in  DATA_BITS  word to transmit.
REQ-009 SHALL have port parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-010 SHALL have port two_stop  in  1  0 one stop bit, 1 two stop bits.
REQ-011 SHALL have port tx  out  1  serial line, idle high, registered.
REQ-012 SHALL have port tx_busy  out  1  frame in progress or FIFO non-empty.
REQ-013 SHALL have port fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in FIFO.

Function
REQ-014 SHALL push in_data into FIFO on any cycle with in_valid=1 and in_ready=1; in_ready = (fifo_count != FIFO_DEPTH).
REQ-015 SHALL keep FIFO order first-in first-out; pointers wrap modulo FIFO_DEPTH.
REQ-016 SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-017 SHALL launch a frame only on a cycle where state=IDLE, tick=1 and FIFO non-empty: pop head word, latch it plus parity_mode and two_stop, enter START; tx=0 from next cycle.
REQ-018 SHALL ignore parity_mode/two_stop changes mid-frame; latched values apply to the whole frame.
REQ-019 SHALL advance between bits only on tick, so every bit lasts exactly one tick interval.
REQ-020 SHALL on tick in START enter DATA and drive data bit 0; DATA sends bits LSB first, bit index 0..DATA_BITS-1.
REQ-021 SHALL on tick at last data bit enter PARITY if latched mode even/odd, else STOP.
REQ-022 SHALL drive parity bit = XOR of data bits for even, inverted XOR for odd.
REQ-023 SHALL drive tx=1 in STOP for one tick interval, or two if latched two_stop=1.
REQ-024 SHALL on the tick ending the final stop bit: if FIFO non-empty, pop and enter START (tx=0 next cycle, zero idle gap); else enter IDLE.
REQ-025 SHALL allow push and pop in the same cycle; fifo_count unchanged then.
REQ-026 SHALL hold tx=1 in IDLE; tick with empty FIFO has no effect.
REQ-027 SHALL drive tx_busy = (state != IDLE) or (fifo_count != 0), combinational from registers.
REQ-028 SHALL never drop or duplicate a word; in_valid while in_ready=0 is not accepted and in_data need not be held by the block.

Reset
REQ-029 SHALL on reset assertion immediately force tx=1, state=IDLE, FIFO empty, fifo_count=0, in_ready=1, tx_busy=0, bit index 0, latched config cleared, including mid-frame (frame truncated).
REQ-030 SHALL resume on first rising clk after reset deassertion; no frame starts before a tick sees a non-empty FIFO.

Verification
REQ-031 SHALL test DATA_BITS=8, tick every 4 clk, mode 00, two_stop=0, push 0x55 -> tx 0,1,0,1,0,1,0,1,0,1 then idle, each level 4 clk, 40 clk frame.
REQ-032 SHALL test push 0x03 with even parity -> parity bit 0; same with odd -> parity bit 1; 11-bit frames.
REQ-033 SHALL test two_stop=1, push 0xFF, change two_stop to 0 mid-frame -> stop high 8 clk (two periods), then idle.
REQ-034 SHALL test FIFO_DEPTH=4, hold tick low, push 5 words 0xA1..0xA5 -> in_ready low after 4th, fifo_count=4; enable tick -> 0xA1..0xA4 sent back-to-back, no idle gap, tx_busy falls after last stop.
REQ-035 SHALL test reset asserted during data bit 3 of a frame with 2 queued -> tx=1 and fifo_count=0 same cycle, no further frames without new pushes.
REQ-036 SHALL test simultaneous push and frame launch with fifo_count=2 -> fifo_count stays 2, order preserved.
